ssr6_to_ssr4_gearbox: RTL

- Converts a 6-samples/clock stream that is valid on 2 of every 3 clocks (the clock-enabled SSR6 domain) back to a continuous 4-samples/clock SSR4 stream.
- Serves as the output gearbox for clock-enabled SSR6 filters, pairing with the SSR4→SSR6 input gearbox.
- Tracks the global clk_phase_i alignment pulse and checks both it and ce_i against the expected 3-clock pattern, raising sticky error flags on mismatch.

---
 rtl/ssr_gearbox_pkg.sv | 14 +
 rtl/ssr6_to_ssr4_gearbox_if.sv | 22 ++
 rtl/ssr_phase_track.sv | 30 +++
 rtl/ssr6_to_ssr4_gearbox.sv | 60 ++++++
 4 files changed

// File: rtl/ssr_gearbox_pkg.sv
// ssr_gearbox_pkg: shared constants and phase type for the SSR4<->SSR6 gearboxes
// Contents: lane counts SSR6_N/SSR4_N, GEAR_PERIOD, gear_phase_t, PH0..PH2, next_phase()
package ssr_gearbox_pkg;
    localparam int SSR6_N      = 6;
    localparam int SSR4_N      = 4;
    localparam int GEAR_PERIOD = 3;
    typedef logic [1:0] gear_phase_t;
    localparam gear_phase_t PH0 = 2'd0;
    localparam gear_phase_t PH1 = 2'd1;
    localparam gear_phase_t PH2 = gear_phase_t'(GEAR_PERIOD - 1);
    function automatic gear_phase_t next_phase(gear_phase_t p);
        return (p == PH2) ? PH0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/ssr6_to_ssr4_gearbox_if.sv
// ssr6_to_ssr4_gearbox_if: SSR6 input / SSR4 output bundle of the output gearbox
// Signals: clk_phase_i, ce_i, dat_i[6], err_clr_i (to gearbox);
//          dat_o[4], valid_o, align_err_o, ce_err_o (from gearbox)
// Modports: master (stream source / sink side), slave (gearbox side)
interface ssr6_to_ssr4_gearbox_if import ssr_gearbox_pkg::*; #(parameter int NBITS = 12);
    logic                            clk_phase_i;
    logic                            ce_i;
    logic [SSR6_N-1:0][NBITS-1:0]    dat_i;
    logic                            err_clr_i;
    logic [SSR4_N-1:0][NBITS-1:0]    dat_o;
    logic                            valid_o;
    logic                            align_err_o;
    logic                            ce_err_o;
    modport master (
        output clk_phase_i, ce_i, dat_i, err_clr_i,
        input  dat_o, valid_o, align_err_o, ce_err_o
    );
    modport slave (
        input  clk_phase_i, ce_i, dat_i, err_clr_i,
        output dat_o, valid_o, align_err_o, ce_err_o
    );
endinterface

// File: rtl/ssr_phase_track.sv
// ssr_phase_track: 3-clock phase counter locked to the global clk_phase_i pulse
// Ports: clk_i, rstn_i (async active-low), clk_phase_i, err_clr_i in;
//        eph (effective phase this cycle), synced (locked, incl. the first pulse cycle),
//        align_err (sticky off-phase pulse flag) out
module ssr_phase_track import ssr_gearbox_pkg::*; (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        clk_phase_i,
    input  logic        err_clr_i,
    output gear_phase_t eph,
    output logic        synced,
    output logic        align_err
);
    gear_phase_t ph;
    logic        synced_q;
    // The pulse itself defines phase 0, so the first pulse cycle already counts as locked.
    assign eph    = clk_phase_i ? PH0 : ph;
    assign synced = synced_q | clk_phase_i;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ph        <= PH0;
            synced_q  <= 1'b0;
            align_err <= 1'b0;
        end else begin
            ph        <= next_phase(eph);
            synced_q  <= synced;
            align_err <= (synced_q && clk_phase_i && ph != PH0) || (align_err && !err_clr_i);
        end
    end
endmodule

// File: rtl/ssr6_to_ssr4_gearbox.sv
// ssr6_to_ssr4_gearbox: clock-enabled SSR6 (6 samples on 2 of 3 clocks) to continuous SSR4
// Ports: clk_i, rstn_i (async active-low); bus (slave modport) carrying clk_phase_i, ce_i,
//        dat_i, err_clr_i in and registered dat_o, valid_o, sticky align_err_o / ce_err_o out
module ssr6_to_ssr4_gearbox import ssr_gearbox_pkg::*; #(parameter int NBITS = 12) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    ssr6_to_ssr4_gearbox_if.slave  bus
);
    gear_phase_t                  eph;
    logic                         synced;
    logic                         align_err;
    logic [SSR6_N-1:0][NBITS-1:0] buf_lo;
    logic [SSR6_N-1:0][NBITS-1:0] buf_hi;
    logic [SSR4_N-1:0][NBITS-1:0] word;
    logic [SSR4_N-1:0][NBITS-1:0] dat_q;
    logic                         got_w0;
    logic                         valid_q;
    logic                         ce_err_q;
    logic                         ce_bad;
    ssr_phase_track u_track (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .clk_phase_i (bus.clk_phase_i),
        .err_clr_i   (bus.err_clr_i),
        .eph         (eph),
        .synced      (synced),
        .align_err   (align_err)
    );
    // The 12-sample group {buf_hi, buf_lo} is emitted as three 4-sample words,
    // one per phase, each built from buffers captured in earlier cycles.
    always_comb begin
        word   = (eph == PH1) ? buf_lo[3:0]
               : (eph == PH2) ? {buf_hi[1:0], buf_lo[5:4]}
               : buf_hi[5:2];
        ce_bad = synced && ((eph == PH2) == bus.ce_i);
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            buf_lo   <= '0;
            buf_hi   <= '0;
            dat_q    <= '0;
            got_w0   <= 1'b0;
            valid_q  <= 1'b0;
            ce_err_q <= 1'b0;
        end else begin
            if (synced) begin
                dat_q <= word;
                if (bus.ce_i && eph == PH0) buf_lo <= bus.dat_i;
                if (bus.ce_i && eph == PH1) buf_hi <= bus.dat_i;
                got_w0  <= got_w0 | (bus.ce_i && eph == PH0);
                valid_q <= valid_q | (eph == PH1 && got_w0);
            end
            ce_err_q <= ce_bad || (ce_err_q && !bus.err_clr_i);
        end
    end
    assign bus.dat_o       = dat_q;
    assign bus.valid_o     = valid_q;
    assign bus.align_err_o = align_err;
    assign bus.ce_err_o    = ce_err_q;
endmodule
